// File: rtl/hw_indicator_pkg.sv
// Shared definitions for the heartbeat blinker and heartbeat monitor blocks.
package hw_indicator_pkg;

    // Default system clock frequency in Hz
    localparam int unsigned DEFAULT_FREQ = 100000000;

    // Monitor FSM states
    localparam logic STATE_SEARCH = 1'b0;
    localparam logic STATE_LOCKED = 1'b1;

    // Cycles between heartbeat toggles for a given clock frequency
    function automatic int unsigned nominal_half_period(input int unsigned freq);
        return freq / 2 + 1;
    endfunction

endpackage

// File: rtl/hw_heartbeat_monitor_if.sv
// Heartbeat input, clear strobe and PIO status bundle of the heartbeat monitor.
interface hw_heartbeat_monitor_if;

    logic        hb;
    logic        clr;
    logic        edge_pulse;
    logic        alive;
    logic        lost;
    logic [31:0] half_period;
    logic [15:0] edge_cnt;
    logic [7:0]  fault_cnt;

    modport master (
        output hb, clr,
        input  edge_pulse, alive, lost, half_period, edge_cnt, fault_cnt
    );

    modport slave (
        input  hb, clr,
        output edge_pulse, alive, lost, half_period, edge_cnt, fault_cnt
    );

endinterface

// File: rtl/hw_sync_edge.sv
// Two-flop synchronizer plus delay flop for an asynchronous level input;
// flags every change of the synchronized level with a one-cycle pulse.
module hw_sync_edge #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic edge_pulse
);

    logic s1;
    logic s2;
    logic s3;

    // Synchronizer chain; reset to the idle level of the far-end source
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= RESET_VAL;
            s2 <= RESET_VAL;
            s3 <= RESET_VAL;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_pulse = s2 ^ s3;

endmodule

// File: rtl/hw_heartbeat_monitor.sv
// Heartbeat monitor: measures the interval between toggles of an asynchronous
// heartbeat, qualifies it against a tolerance window and reports lock status
// and loss statistics.
module hw_heartbeat_monitor
    import hw_indicator_pkg::*;
#(
    parameter int unsigned FREQ       = DEFAULT_FREQ,
    parameter int unsigned TOL        = FREQ / 8,
    parameter int unsigned LOCK_COUNT = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    hw_heartbeat_monitor_if.slave bus
);

    localparam int unsigned NOMINAL = nominal_half_period(FREQ);
    localparam logic [31:0] TMAX    = 32'(NOMINAL + TOL);
    localparam logic [31:0] TMIN    = 32'(NOMINAL - TOL);
    localparam int GOOD_W           = $clog2(LOCK_COUNT + 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);

    logic              hb_edge;
    logic              state;
    logic              first;
    logic [GOOD_W-1:0] good;
    logic [31:0]       cnt;
    logic [31:0]       interval;
    logic              in_window;
    logic              timeout;
    logic              loss;

    hw_sync_edge #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (bus.hb),
        .edge_pulse (hb_edge)
    );

    assign interval  = cnt + 32'd1;
    assign in_window = (interval >= TMIN) && (interval <= TMAX);
    // Saturation keeps cnt from matching TMAX a second time within one gap
    assign timeout   = !hb_edge && (cnt == TMAX);
    assign loss      = (state == STATE_LOCKED) &&
                       ((hb_edge && !first && !in_window) || timeout);

    assign bus.alive = (state == STATE_LOCKED);

    // Interval counter: restarts on each toggle, saturates while the line is idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (hb_edge) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 32'd1;
        end
    end

    // Per-toggle measurement outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.edge_pulse  <= 1'b0;
            bus.half_period <= '0;
            bus.edge_cnt    <= '0;
        end else begin
            bus.edge_pulse <= hb_edge;
            if (hb_edge) begin
                bus.half_period <= interval;
                bus.edge_cnt    <= bus.edge_cnt + 16'd1;
            end
        end
    end

    // Lock FSM; the first toggle after reset or a timeout only starts a measurement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STATE_SEARCH;
            first <= 1'b1;
            good  <= '0;
        end else if (hb_edge) begin
            if (first) begin
                first <= 1'b0;
            end else if (state == STATE_SEARCH) begin
                if (in_window) begin
                    if (good == GOOD_LAST) begin
                        state <= STATE_LOCKED;
                        good  <= '0;
                    end else begin
                        good <= good + GOOD_W'(1);
                    end
                end else begin
                    good <= '0;
                end
            end else if (!in_window) begin
                state <= STATE_SEARCH;
                good  <= '0;
            end
        end else if (timeout) begin
            state <= STATE_SEARCH;
            first <= 1'b1;
            good  <= '0;
        end
    end

    // Sticky loss flag and saturating loss counter; a coincident loss beats clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.lost      <= 1'b0;
            bus.fault_cnt <= '0;
        end else if (loss) begin
            bus.lost <= 1'b1;
            if (bus.clr) begin
                bus.fault_cnt <= 8'd1;
            end else if (bus.fault_cnt != 8'hFF) begin
                bus.fault_cnt <= bus.fault_cnt + 8'd1;
            end
        end else if (bus.clr) begin
            bus.lost      <= 1'b0;
            bus.fault_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_hw_heartbeat_monitor.sv
// Testbench for hw_heartbeat_monitor: directed lock/loss/clear/reset scenarios
// followed by randomized toggle intervals, checked every cycle against a
// timestamp-based model of the monitor.
module tb_hw_heartbeat_monitor;

    localparam int unsigned FREQ       = 20;
    localparam int unsigned TOL        = 2;
    localparam int unsigned LOCK_COUNT = 4;
    localparam int unsigned NOMINAL    = FREQ / 2 + 1;
    localparam int unsigned TMIN       = NOMINAL - TOL;
    localparam int unsigned TMAX       = NOMINAL + TOL;

    // Model state: cycle timestamps since reset instead of a running counter
    typedef struct {
        int unsigned n;
        int unsigned last;
        bit          first;
        bit          locked;
        int unsigned good;
        bit          lost;
        int unsigned fault;
        bit          pulse;
        logic [31:0] half;
        logic [15:0] ecnt;
        bit   [2:0]  samp;
    } model_t;

    logic   clk;
    logic   rst_n;
    model_t m;
    int     n_checks;
    int     n_fail;

    hw_heartbeat_monitor_if hbi ();

    hw_heartbeat_monitor #(
        .FREQ       (FREQ),
        .TOL        (TOL),
        .LOCK_COUNT (LOCK_COUNT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hbi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic model_t model_reset();
        model_t r;
        r.n      = 0;
        r.last   = 0;
        r.first  = 1'b1;
        r.locked = 1'b0;
        r.good   = 0;
        r.lost   = 1'b0;
        r.fault  = 0;
        r.pulse  = 1'b0;
        r.half   = '0;
        r.ecnt   = '0;
        r.samp   = 3'b111;
        return r;
    endfunction

    // A toggle becomes visible three clock edges after it is driven; interval
    // is the distance between visible toggles, timeout is TMAX+1 cycles of silence
    function automatic model_t model_step(input model_t s, input bit hb, input bit clr);
        model_t      r;
        bit          lose;
        int unsigned iv;
        bit          inwin;
        r     = s;
        lose  = 1'b0;
        r.n   = s.n + 1;
        r.pulse = (s.samp[1] != s.samp[2]);
        r.samp  = {s.samp[1:0], hb};
        iv    = r.n - s.last;
        inwin = (iv >= TMIN) && (iv <= TMAX);
        if (r.pulse) begin
            r.half = iv;
            r.ecnt = s.ecnt + 16'd1;
            r.last = r.n;
            if (s.first) begin
                r.first = 1'b0;
            end else if (!s.locked) begin
                if (inwin) begin
                    r.good = s.good + 1;
                    if (r.good == LOCK_COUNT) begin
                        r.locked = 1'b1;
                        r.good   = 0;
                    end
                end else begin
                    r.good = 0;
                end
            end else if (!inwin) begin
                lose = 1'b1;
            end
        end else if (iv - 1 == TMAX) begin
            r.first = 1'b1;
            r.good  = 0;
            if (s.locked) lose = 1'b1;
        end
        if (lose) begin
            r.locked = 1'b0;
            r.good   = 0;
            r.lost   = 1'b1;
            r.fault  = clr ? 1 : ((s.fault < 255) ? s.fault + 1 : 255);
        end else if (clr) begin
            r.lost  = 1'b0;
            r.fault = 0;
        end
        return r;
    endfunction

    function automatic void check_output(input string name, input logic [63:0] actual,
                                         input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endfunction

    // Reference model advances on the same edges the DUT samples its inputs
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_step(m, hbi.hb, hbi.clr);
    end

    // Compare process: every output against the model, away from the active edge
    always @(negedge clk) begin
        check_output("cmp_edge",        64'(hbi.edge_pulse),  64'(m.pulse));
        check_output("cmp_alive",       64'(hbi.alive),       64'(m.locked));
        check_output("cmp_lost",        64'(hbi.lost),        64'(m.lost));
        check_output("cmp_half_period", 64'(hbi.half_period), 64'(m.half));
        check_output("cmp_edge_cnt",    64'(hbi.edge_cnt),    64'(m.ecnt));
        check_output("cmp_fault_cnt",   64'(hbi.fault_cnt),   64'(m.fault));
    end

    task automatic wait_cycles(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold the heartbeat for gap cycles (optionally pulsing clr) then toggle it
    task automatic apply_stimulus(input int gap, input int clr_at);
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
            hbi.clr = (i == clr_at) && (i < gap - 1);
        end
        hbi.hb = ~hbi.hb;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_edge"},      64'(hbi.edge_pulse),  0);
        check_output({tag, "_alive"},     64'(hbi.alive),       0);
        check_output({tag, "_lost"},      64'(hbi.lost),        0);
        check_output({tag, "_half"},      64'(hbi.half_period), 0);
        check_output({tag, "_edge_cnt"},  64'(hbi.edge_cnt),    0);
        check_output({tag, "_fault_cnt"}, 64'(hbi.fault_cnt),   0);
    endtask

    initial begin
        int gap;
        int clr_at;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        hbi.hb   = 1'b1;
        hbi.clr  = 1'b0;

        // Reset state
        wait_cycles(3);
        check_all_zero("reset");
        #1 rst_n = 1'b1;

        // Nominal toggling: lock after the fifth visible toggle
        for (int i = 0; i < 5; i++) apply_stimulus(11, -1);
        check_output("pre_lock_alive", 64'(hbi.alive), 0);
        check_output("pre_lock_edge_cnt", 64'(hbi.edge_cnt), 4);
        wait_cycles(2);
        check_output("edge_latency_early", 64'(hbi.edge_pulse), 0);
        wait_cycles(1);
        check_output("edge_latency_hit", 64'(hbi.edge_pulse), 1);
        check_output("lock_alive", 64'(hbi.alive), 1);
        check_output("lock_edge_cnt", 64'(hbi.edge_cnt), 5);
        check_output("lock_half_period", 64'(hbi.half_period), 11);
        wait_cycles(1);
        check_output("edge_one_cycle", 64'(hbi.edge_pulse), 0);
        apply_stimulus(7, -1);

        // Stop toggling: timeout loss, then re-lock with lost still set
        wait_cycles(16);
        check_output("pre_timeout_alive", 64'(hbi.alive), 1);
        wait_cycles(1);
        check_output("timeout_alive", 64'(hbi.alive), 0);
        check_output("timeout_lost", 64'(hbi.lost), 1);
        check_output("timeout_fault", 64'(hbi.fault_cnt), 1);
        for (int i = 0; i < 6; i++) apply_stimulus(11, -1);
        check_output("relock_alive", 64'(hbi.alive), 1);
        check_output("relock_lost_sticky", 64'(hbi.lost), 1);

        // Window boundaries 9 and 13 keep lock, 8 loses it
        apply_stimulus(9, -1);
        apply_stimulus(13, -1);
        apply_stimulus(8, -1);
        wait_cycles(3);
        check_output("short_alive", 64'(hbi.alive), 0);
        check_output("short_half_period", 64'(hbi.half_period), 8);
        check_output("short_fault", 64'(hbi.fault_cnt), 2);
        apply_stimulus(8, -1);
        for (int i = 0; i < 3; i++) apply_stimulus(11, -1);
        wait_cycles(3);
        check_output("relock2_alive", 64'(hbi.alive), 1);
        wait_cycles(10);
        check_output("long_pre_alive", 64'(hbi.alive), 1);
        apply_stimulus(1, -1);
        wait_cycles(3);
        check_output("long_alive", 64'(hbi.alive), 0);
        check_output("long_fault", 64'(hbi.fault_cnt), 3);

        // Clear coinciding with a timeout loss, then a lone clear while locked
        apply_stimulus(8, -1);
        for (int i = 0; i < 3; i++) apply_stimulus(11, -1);
        wait_cycles(3);
        check_output("relock3_alive", 64'(hbi.alive), 1);
        wait_cycles(13);
        hbi.clr = 1'b1;
        wait_cycles(1);
        hbi.clr = 1'b0;
        check_output("clr_loss_lost", 64'(hbi.lost), 1);
        check_output("clr_loss_fault", 64'(hbi.fault_cnt), 1);
        check_output("clr_loss_alive", 64'(hbi.alive), 0);
        for (int i = 0; i < 5; i++) apply_stimulus(11, -1);
        wait_cycles(3);
        check_output("relock4_alive", 64'(hbi.alive), 1);
        hbi.clr = 1'b1;
        wait_cycles(1);
        hbi.clr = 1'b0;
        check_output("clr_lost", 64'(hbi.lost), 0);
        check_output("clr_fault", 64'(hbi.fault_cnt), 0);
        check_output("clr_alive", 64'(hbi.alive), 1);

        // Asynchronous reset while locked
        #2;
        rst_n  = 1'b0;
        hbi.hb = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) apply_stimulus(11, -1);
        check_output("post_reset_alive_early", 64'(hbi.alive), 0);
        apply_stimulus(11, -1);
        check_output("post_reset_alive", 64'(hbi.alive), 1);
        check_output("post_reset_edge_cnt", 64'(hbi.edge_cnt), 5);

        // Randomized intervals around and beyond the window, with random clears
        for (int it = 0; it < 150; it++) begin
            int r;
            r = int'($urandom_range(0, 15));
            if (r < 10)      gap = int'($urandom_range(TMIN, TMAX));
            else if (r < 13) gap = int'($urandom_range(5, 16));
            else             gap = int'($urandom_range(17, 40));
            clr_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, gap - 2)) : -1;
            apply_stimulus(gap, clr_at);
        end
        wait_cycles(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
